step_output_shaper: RTL and testbench

- Sits directly downstream of each pulsegen channel, between the raw step/dir outputs and the driver pins.
- Queues incoming step requests together with their direction.
- Replays them to the stepper driver while enforcing direction setup, step-high and step-low minimum times.
- Times everything on the shared pulse_clk tick from freq_divider.
- One instance per axis, so stepper_pulse/stepper_dir never violate driver timing, even with bursty pulsegen output.

---
 rtl/step_shaper_pkg.sv | 16 +
 rtl/step_req_fifo.sv | 57 +++++
 rtl/step_output_shaper.sv | 183 ++++++++++++++++++
 tb/tb_step_output_shaper.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_shaper_pkg.sv
// Shared types and constants for the step output shaper.
// Holds the shaper state enum and the default timing-length and phase-counter widths.
package step_shaper_pkg;

    // The phase counter is loaded straight from a length input, so the widths match.
    localparam int unsigned TICK_CNT_W    = 5;
    localparam int unsigned DEFAULT_LEN_W = TICK_CNT_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIR_SETUP = 2'd1,
        STEP_HIGH = 2'd2,
        STEP_LOW  = 2'd3
    } shaper_state_e;

endpackage

// File: rtl/step_req_fifo.sv
// 1-bit-wide synchronous FIFO holding the direction of each pending step request.
// Show-ahead read: dout is the oldest entry whenever empty is low.
module step_req_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   din,
    output logic                   dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // NOTE: storage has no reset; count_q gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/step_output_shaper.sv
// Queues raw step/dir requests and replays them with enforced dir-setup, step-high and step-low times.
// Optional signed position counter enabled by defining STEP_POS_COUNT_EN.
module step_output_shaper
    import step_shaper_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = DEFAULT_LEN_W,
    parameter bit DIR_RESET  = 1'b0,
    parameter int POS_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic                        step_in,
    input  logic                        dir_in,
    input  logic                        abort,
    input  logic [LEN_W-1:0]            step_high_len,
    input  logic [LEN_W-1:0]            step_low_len,
    input  logic [LEN_W-1:0]            dir_setup_len,
    input  logic                        overrun_clr,
    output logic                        step_out,
    output logic                        dir_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] pending,
`ifdef STEP_POS_COUNT_EN
    output logic signed [POS_W-1:0]     position,
`endif
    output logic                        overrun
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        LEN_W < 1 || POS_W < 1) begin : g_bad_params
        $error("step_output_shaper: illegal parameter value");
    end

    shaper_state_e    state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_prev_q;
    logic             tick_q, tick_prev_q;
    logic             dir_out_q, dir_out_d;
    logic             step_out_q, step_out_d;
    logic             overrun_q, overrun_d;

    logic step_rise, tick_rise, push_req, drop;
    logic fifo_push, fifo_pop, fifo_dout, fifo_full, fifo_empty;

    function automatic logic [LEN_W-1:0] len_or_one(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

    assign step_rise = step_q && !step_prev_q;
    assign tick_rise = tick_q && !tick_prev_q;
    assign push_req  = step_rise && !abort;
    assign drop      = push_req && fifo_full && !fifo_pop;
    assign fifo_push = push_req && !drop;

    step_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (dir_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            tick_prev_q <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            dir_out_q   <= DIR_RESET;
            step_out_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            step_q      <= step_in;
            step_prev_q <= step_q;
            tick_q      <= tick;
            tick_prev_q <= tick_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_out_q   <= dir_out_d;
            step_out_q  <= step_out_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        if (fifo_dout != dir_out_q) begin
                            state_d = DIR_SETUP;
                            cnt_d   = len_or_one(dir_setup_len);
                        end else begin
                            state_d = STEP_HIGH;
                            cnt_d   = len_or_one(step_high_len);
                        end
                    end
                end
                DIR_SETUP: begin
                    if (tick_rise) begin
                        if (cnt_q <= LEN_W'(1)) begin
                            state_d = STEP_HIGH;
                            cnt_d   = len_or_one(step_high_len);
                        end else begin
                            cnt_d = cnt_q - LEN_W'(1);
                        end
                    end
                end
                STEP_HIGH: begin
                    if (tick_rise) begin
                        if (cnt_q <= LEN_W'(1)) begin
                            state_d = STEP_LOW;
                            cnt_d   = len_or_one(step_low_len);
                        end else begin
                            cnt_d = cnt_q - LEN_W'(1);
                        end
                    end
                end
                STEP_LOW: begin
                    if (tick_rise) begin
                        if (cnt_q <= LEN_W'(1)) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - LEN_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so step_out is high from the STEP_HIGH entry cycle.
    always_comb begin
        step_out_d = (state_d == STEP_HIGH);
        dir_out_d  = dir_out_q;
        if (state_q == IDLE && state_d == DIR_SETUP) begin
            dir_out_d = fifo_dout;
        end
        overrun_d = overrun_q;
        if (overrun_clr) overrun_d = 1'b0;
        if (drop)        overrun_d = 1'b1;
    end

    assign step_out = step_out_q;
    assign dir_out  = dir_out_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

`ifdef STEP_POS_COUNT_EN
    logic signed [POS_W-1:0] pos_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else if (state_q != STEP_HIGH && state_d == STEP_HIGH) begin
            pos_q <= pos_q + (dir_out_q ? POS_W'(1) : {POS_W{1'b1}});
        end
    end

    assign position = pos_q;
`endif

endmodule

// File: tb/tb_step_output_shaper.sv
// Directed self-checking bench for step_output_shaper: timing table plus overrun, abort and reset sequences.
// Ticks arrive every 4 clk (1 clk high), so a phase of N ticks lasts 4N clk when entered on a tick.
module tb_step_output_shaper;

    localparam int FIFO_DEPTH = 4;
    localparam int LEN_W      = 5;
    localparam int PEND_W     = $clog2(FIFO_DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              tick;
    logic              step_in;
    logic              dir_in;
    logic              abort;
    logic              overrun_clr;
    logic [LEN_W-1:0]  step_high_len;
    logic [LEN_W-1:0]  step_low_len;
    logic [LEN_W-1:0]  dir_setup_len;
    logic              step_out;
    logic              dir_out;
    logic              busy;
    logic              overrun;
    logic [PEND_W-1:0] pending;
`ifdef STEP_POS_COUNT_EN
    logic signed [15:0] position;
    int                 exp_pos;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic tick_run = 1'b0;
    int   tdiv     = 0;
    int   rises    = 0;
    int   falls    = 0;
    int   hi_run   = 0;
    int   hi_min   = 9999;
    int   hi_max   = 0;
    int   dir_viol = 0;
    logic prev_step = 1'b0;
    logic prev_dir  = 1'b0;
    logic exp_dir   = 1'b0;

    typedef struct {
        logic [LEN_W-1:0] high;
        logic [LEN_W-1:0] low;
        logic [LEN_W-1:0] setup;
        logic             dir;
        logic             chg;
        int               setup_min;
        int               setup_max;
        int               high_min;
        int               high_max;
        int               low_clk;
    } vec_t;

    vec_t vecs[6];

    step_output_shaper #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEN_W      (LEN_W),
        .DIR_RESET  (1'b0),
        .POS_W      (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .step_in       (step_in),
        .dir_in        (dir_in),
        .abort         (abort),
        .step_high_len (step_high_len),
        .step_low_len  (step_low_len),
        .dir_setup_len (dir_setup_len),
        .overrun_clr   (overrun_clr),
        .step_out      (step_out),
        .dir_out       (dir_out),
        .busy          (busy),
        .pending       (pending),
`ifdef STEP_POS_COUNT_EN
        .position      (position),
`endif
        .overrun       (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tdiv = (tdiv + 1) % 4;
            tick = tick_run && (tdiv == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (step_out && !prev_step) rises++;
                if (!step_out && prev_step) begin
                    falls++;
                    if (hi_run < hi_min) hi_min = hi_run;
                    if (hi_run > hi_max) hi_max = hi_run;
                end
                hi_run = step_out ? hi_run + 1 : 0;
                if (dir_out != prev_dir && (step_out || prev_step)) dir_viol++;
            end
            prev_step = step_out;
            prev_dir  = dir_out;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic push_edges(input int count, input logic dir);
        for (int k = 0; k < count; k++) begin
            @(negedge clk);
            dir_in  = dir;
            step_in = 1'b1;
            @(negedge clk);
            step_in = 1'b0;
        end
    endtask

    task automatic reset_stats();
        rises  = 0;
        falls  = 0;
        hi_min = 9999;
        hi_max = 0;
    endtask

    task automatic run_vec(input int i);
        vec_t v = vecs[i];
        int   cyc = 0;
        int   t_dir = -1;
        int   hi = 0;
        int   lo = 0;
        logic dir0;
        @(negedge clk);
        step_high_len = v.high;
        step_low_len  = v.low;
        dir_setup_len = v.setup;
        dir_in        = v.dir;
        step_in       = 1'b1;
        dir0          = dir_out;
        while (!step_out && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) step_in = 1'b0;
            if (dir_out != dir0 && t_dir < 0) t_dir = cyc;
        end
        step_in = 1'b0;
        check($sformatf("v%0d_step_seen", i), step_out, 1'b1);
        check($sformatf("v%0d_dir_changed", i), (t_dir >= 0), v.chg);
        if (v.chg) check_range($sformatf("v%0d_setup_clk", i), cyc - t_dir, v.setup_min, v.setup_max);
        while (step_out && hi < 2000) begin
            @(negedge clk);
            hi++;
        end
        check_range($sformatf("v%0d_high_clk", i), hi, v.high_min, v.high_max);
        while (busy && lo < 2000) begin
            @(negedge clk);
            lo++;
        end
        check($sformatf("v%0d_low_clk", i), lo, v.low_clk);
        check($sformatf("v%0d_idle", i), busy, 1'b0);
        check($sformatf("v%0d_dir_out", i), dir_out, v.dir);
        exp_dir = v.dir;
`ifdef STEP_POS_COUNT_EN
        exp_pos = exp_pos + (v.dir ? 1 : -1);
        check($sformatf("v%0d_position", i), 32'(position) & 32'hFFFF, 32'(exp_pos) & 32'hFFFF);
`endif
    endtask

    initial begin
        //            high   low    setup  dir   chg   smin smax hmin hmax low
        vecs[0] = '{5'd3,  5'd2, 5'd4, 1'b0, 1'b0, 0,   0,   9,   12,  8};
        vecs[1] = '{5'd1,  5'd1, 5'd4, 1'b1, 1'b1, 13,  16,  4,   4,   4};
        vecs[2] = '{5'd0,  5'd0, 5'd0, 1'b0, 1'b1, 1,   4,   4,   4,   4};
        vecs[3] = '{5'd5,  5'd3, 5'd2, 1'b0, 1'b0, 0,   0,   17,  20,  12};
        vecs[4] = '{5'd2,  5'd0, 5'd1, 1'b1, 1'b1, 1,   4,   8,   8,   4};
        vecs[5] = '{5'd31, 5'd1, 5'd0, 1'b1, 1'b0, 0,   0,   121, 124, 4};
`ifdef STEP_POS_COUNT_EN
        exp_pos = 0;
`endif

        rst_n         = 1'b0;
        step_in       = 1'b0;
        dir_in        = 1'b0;
        abort         = 1'b0;
        overrun_clr   = 1'b0;
        step_high_len = '0;
        step_low_len  = '0;
        dir_setup_len = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_step_out", step_out, 1'b0);
        check("rst_dir_out", dir_out, 1'b0);
        check("rst_pending", pending, 0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
`ifdef STEP_POS_COUNT_EN
        check("rst_position", 32'(position) & 32'hFFFF, 0);
`endif

        tick_run = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 6; i++) run_vec(i);
        repeat (4) @(negedge clk);

        // Burst with tick held low: one request popped, four queued, one dropped.
        tick_run = 1'b0;
        step_high_len = 5'd1;
        step_low_len  = 5'd1;
        dir_setup_len = 5'd1;
        repeat (6) @(negedge clk);
        push_edges(6, exp_dir);
        repeat (3) @(negedge clk);
        check("burst_pending", pending, 4);
        check("burst_overrun", overrun, 1'b1);
        check("burst_stalled_high", step_out, 1'b1);
        check("burst_busy", busy, 1'b1);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("overrun_cleared", overrun, 1'b0);
        // Drop and clear in the same cycle: set wins.
        step_in = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        step_in     = 1'b0;
        check("overrun_set_wins", overrun, 1'b1);
        check("burst_pending_full", pending, 4);
        reset_stats();
        tick_run = 1'b1;
        wait_idle("burst_drain", 1000);
        check("burst_pulses", falls, 5);
        check("burst_pending_after", pending, 0);
        check("overrun_sticky", overrun, 1'b1);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("overrun_cleared2", overrun, 1'b0);

        // Zero lengths: every phase lasts one tick.
        step_high_len = 5'd0;
        step_low_len  = 5'd0;
        dir_setup_len = 5'd0;
        repeat (4) @(negedge clk);
        reset_stats();
        push_edges(3, exp_dir);
        wait_idle("zero_drain", 1000);
        check("zero_rises", rises, 3);
        check("zero_falls", falls, 3);
        check_range("zero_high_max", hi_max, 1, 4);
        check_range("zero_high_min", hi_min, 1, 4);

        // Abort mid-STEP_HIGH with two pending and a step edge in the abort cycle.
        tick_run = 1'b0;
        step_high_len = 5'd3;
        step_low_len  = 5'd1;
        dir_setup_len = 5'd1;
        repeat (6) @(negedge clk);
        push_edges(3, exp_dir);
        repeat (3) @(negedge clk);
        check("abort_pre_pending", pending, 2);
        check("abort_pre_high", step_out, 1'b1);
        step_in = 1'b1;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        step_in = 1'b0;
        check("abort_step_out", step_out, 1'b0);
        check("abort_pending", pending, 0);
        check("abort_busy", busy, 1'b0);
        check("abort_dir_kept", dir_out, exp_dir);
        check("abort_no_overrun", overrun, 1'b0);
        reset_stats();
        tick_run = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_no_pulses", rises, 0);
        check("abort_still_idle", busy, 1'b0);

        check("dir_change_while_step", dir_viol, 0);

        // Reset in the middle of a long step-high phase with dir_out=1.
        step_high_len = 5'd20;
        push_edges(1, 1'b1);
        begin
            int n = 0;
            while (!step_out && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("rstmid_high_seen", step_out, 1'b1);
        check("rstmid_dir_before", dir_out, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("rstmid_step_out", step_out, 1'b0);
        check("rstmid_dir_out", dir_out, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_pending", pending, 0);
        check("rstmid_overrun", overrun, 1'b0);
`ifdef STEP_POS_COUNT_EN
        check("rstmid_position", 32'(position) & 32'hFFFF, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
